// File: rtl/ppt_shot_sequencer.sv
// Thruster firing sequencer: runs N shots of charge -> fire -> cooldown,
// gating the capacitor charger and pulse generator and reporting status.
module ppt_shot_sequencer #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SHOT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_fault,
  input  logic [SHOT_W-1:0] cfg_shots,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_charge_to,
  input  logic [CNT_W-1:0]  cfg_cooldown,
  input  logic              cap_ready,
  output logic              charge_en,
  output logic              gen_run,
  output logic [CNT_W-1:0]  gen_period,
  output logic [CNT_W-1:0]  gen_width,
  output logic              busy,
  output logic [SHOT_W-1:0] shots_done,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_FIRE   = 3'd2,
    S_COOL   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   charge_to_q, cooldown_q;
  logic [SHOT_W-1:0]  shots_q;
  logic [SHOT_W-1:0]  shots_done_d;
  logic               latch_cfg;
  logic               done_d, aborted_d, cfg_err_d;

  // Next-state, counter and pulse decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shots_done_d = shots_done;
    latch_cfg    = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    cfg_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_width > cfg_period) begin
            cfg_err_d = 1'b1;
          end else begin
            latch_cfg    = 1'b1;
            shots_done_d = '0;
            if (cfg_shots == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_CHARGE;
              cnt_d   = '0;
            end
          end
        end
      end

      S_CHARGE: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (cap_ready) begin
          state_d = S_FIRE;
          cnt_d   = '0;
        end else if (charge_to_q == '0 || cnt_q == charge_to_q - CNT_W'(1)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Generator counts 0..period inclusive, so FIRE lasts period+1 cycles
      S_FIRE: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == gen_period) begin
          state_d      = S_COOL;
          cnt_d        = '0;
          shots_done_d = shots_done + SHOT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_COOL: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (cooldown_q == '0 || cnt_q == cooldown_q - CNT_W'(1)) begin
          cnt_d = '0;
          if (shots_done == shots_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_CHARGE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FAULT: begin
        if (clr_fault) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, latched config and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      charge_to_q <= '0;
      cooldown_q  <= '0;
      shots_q     <= '0;
      gen_period  <= '0;
      gen_width   <= '0;
      shots_done  <= '0;
      charge_en   <= 1'b0;
      gen_run     <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shots_done <= shots_done_d;
      if (latch_cfg) begin
        charge_to_q <= cfg_charge_to;
        cooldown_q  <= cfg_cooldown;
        shots_q     <= cfg_shots;
        gen_period  <= cfg_period;
        gen_width   <= cfg_width;
      end
      charge_en <= (state_d == S_CHARGE);
      gen_run   <= (state_d == S_FIRE);
      busy      <= (state_d == S_CHARGE) || (state_d == S_FIRE) || (state_d == S_COOL);
      fault     <= (state_d == S_FAULT);
      done      <= done_d;
      aborted   <= aborted_d;
      cfg_err   <= cfg_err_d;
    end
  end

endmodule
